// File: rtl/wake_sequencer.sv
// Turns the classifier's per-frame class stream into a debounced, time-limited host wake pulse with a refractory period.
// Wake rises one cycle after the confirming last beat; ready_o is high from the cycle after reset and never back-pressures.
module wake_sequencer #(
   parameter int NUM_CLASSES    = 3,
   parameter int WAKE_CLASS     = 0,
   parameter int CONFIRM_FRAMES = 2,
   parameter int HOLD_LEN       = 1024,
   parameter int COOLDOWN_LEN   = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_CLASSES-1:0] data_i,
   input  logic                   valid_i,
   input  logic                   last_i,
   output logic                   ready_o,
   input  logic                   wake_ack_i,
   output logic                   wake_o,
   output logic [1:0]             state_o,
   output logic [7:0]             wake_count_o
);

   localparam int MAX_LEN = (HOLD_LEN > COOLDOWN_LEN) ? HOLD_LEN : COOLDOWN_LEN;
   localparam int CTR_W   = $clog2(MAX_LEN + 1);
   localparam int CNT_W   = $clog2(CONFIRM_FRAMES + 1);

   localparam logic [CTR_W-1:0] HOLD_LAST    = CTR_W'(HOLD_LEN - 1);
   localparam logic [CTR_W-1:0] COOL_LAST    = CTR_W'((COOLDOWN_LEN > 0) ? COOLDOWN_LEN - 1 : 0);
   localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_LISTEN   = 2'd0,
      ST_WAKE     = 2'd1,
      ST_COOLDOWN = 2'd2
   } state_t;

   state_t           state;
   logic             flag;
   logic [CNT_W-1:0] confirm;
   logic [CTR_W-1:0] timer;
   logic             accept;
   logic             hit;
   logic             unused_classes;

   assign accept  = valid_i & ready_o;
   assign hit     = data_i[WAKE_CLASS];
   assign state_o = state;

   // Only the wake-class bit matters; the other class flags are deliberately ignored.
   assign unused_classes = ^data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_LISTEN;
         wake_o       <= 1'b0;
         ready_o      <= 1'b0;
         wake_count_o <= 8'd0;
         flag         <= 1'b0;
         confirm      <= '0;
         timer        <= '0;
      end else begin
         ready_o <= 1'b1;
         case (state)
            ST_LISTEN: begin
               wake_o <= 1'b0;
               if (accept) begin
                  if (last_i) begin
                     flag <= 1'b0;
                     if (flag | hit) begin
                        if (confirm == CONFIRM_LAST) begin
                           state   <= ST_WAKE;
                           wake_o  <= 1'b1;
                           confirm <= '0;
                           timer   <= '0;
                           if (wake_count_o != 8'hFF)
                              wake_count_o <= wake_count_o + 8'd1;
                        end else begin
                           confirm <= confirm + CNT_W'(1);
                        end
                     end else begin
                        confirm <= '0;
                     end
                  end else if (hit) begin
                     flag <= 1'b1;
                  end
               end
            end

            ST_WAKE: begin
               flag    <= 1'b0;
               confirm <= '0;
               // timer counts completed high cycles; the last one ends on this edge.
               if (wake_ack_i || (timer == HOLD_LAST)) begin
                  wake_o <= 1'b0;
                  timer  <= '0;
                  state  <= (COOLDOWN_LEN > 0) ? ST_COOLDOWN : ST_LISTEN;
               end else begin
                  wake_o <= 1'b1;
                  timer  <= timer + CTR_W'(1);
               end
            end

            ST_COOLDOWN: begin
               flag    <= 1'b0;
               confirm <= '0;
               wake_o  <= 1'b0;
               if (timer == COOL_LAST) begin
                  timer <= '0;
                  state <= ST_LISTEN;
               end else begin
                  timer <= timer + CTR_W'(1);
               end
            end

            default: begin
               state   <= ST_LISTEN;
               wake_o  <= 1'b0;
               flag    <= 1'b0;
               confirm <= '0;
               timer   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wake_sequencer.sv
// Scoreboard bench for wake_sequencer: each test queues per-cycle stimulus with its expected outputs, then replays and compares.
module tb_wake_sequencer;

   localparam int HOLD = 8;
   localparam int COOL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] data;
   logic       valid;
   logic       last;
   logic       ready;
   logic       ack;
   logic       wake;
   logic [1:0] state;
   logic [7:0] wcount;

   wake_sequencer #(
      .NUM_CLASSES   (3),
      .WAKE_CLASS    (0),
      .CONFIRM_FRAMES(2),
      .HOLD_LEN      (HOLD),
      .COOLDOWN_LEN  (COOL)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .data_i      (data),
      .valid_i     (valid),
      .last_i      (last),
      .ready_o     (ready),
      .wake_ack_i  (ack),
      .wake_o      (wake),
      .state_o     (state),
      .wake_count_o(wcount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       v;
      logic [2:0] d;
      logic       l;
      logic       ack;
   } stim_t;

   typedef struct packed {
      logic       rdy;
      logic       w;
      logic [1:0] st;
      logic [7:0] cnt;
   } obs_t;

   stim_t stim_q[$];
   obs_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic push(input logic r, input logic v, input logic [2:0] d, input logic l,
                       input logic a, input logic w, input logic [1:0] st);
      stim_t s;
      obs_t  e;
      s = '{rst: r, v: v, d: d, l: l, ack: a};
      e = '{rdy: ~r, w: w, st: st, cnt: exp_cnt};
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic bump_cnt();
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
   endtask

   // 4-beat frame, wake-class flag on beat 2 when positive; a distractor class bit on beat 1.
   task automatic frame(input logic pos, input logic wakes);
      for (int i = 0; i < 4; i++) begin
         if (i == 3 && wakes) begin
            bump_cnt();
            push(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'd1);
         end else begin
            push(1'b0, 1'b1, (i == 0) ? 3'b010 : ((pos && i == 1) ? 3'b001 : 3'b000),
                 (i == 3), 1'b0, 1'b0, 2'd0);
         end
      end
   endtask

   // Cycles following the first WAKE observation; ack_at is the WAKE cycle (1-based) carrying ack, 0 for none.
   task automatic wake_tail(input int ack_at);
      if (ack_at != 0) begin
         for (int i = 1; i < ack_at; i++) push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
         push(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd2);
      end else begin
         for (int i = 1; i < HOLD; i++) push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
         push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd2);
      end
      for (int i = 1; i < COOL; i++) push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd2);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic apply_and_step(input stim_t s);
      rst   = s.rst;
      valid = s.v;
      data  = s.d;
      last  = s.l;
      ack   = s.ack;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      exp_cnt = 8'd0;
      push(1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 2'd0);
      push(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL reset cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   task automatic test_basic_wake();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL basic_wake cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   task automatic test_neg_breaks();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      frame(1'b1, 1'b0);
      frame(1'b0, 1'b0);
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL neg_breaks cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   task automatic test_ack();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0);
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(3);
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(1);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL ack cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   // Positive frames keep flowing through WAKE/COOLDOWN; the frame straddling the COOLDOWN exit loses its flagged beat.
   task automatic test_stream_through();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      int    t;
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
      for (int i = 0; i < 12; i++) begin
         t = 3 + i;
         push(1'b0, 1'b1, ((i % 4) == 1) ? 3'b001 : 3'b000, ((i % 4) == 3), 1'b0,
              (t < HOLD), (t < HOLD) ? 2'd1 : ((t < HOLD + COOL) ? 2'd2 : 2'd0));
      end
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(2);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL stream_through cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid_wake();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd1);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL reset_mid_wake cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
      exp_cnt = 8'd0;
      push(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
      push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
      frame(1'b1, 1'b0);
      frame(1'b1, 1'b1);
      wake_tail(0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL reset_mid_wake_after cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   // Single-beat frames with invalid look-alike beats interleaved; each wake is acked at once to keep the run short.
   task automatic test_saturation();
      stim_t s;
      obs_t  e, a;
      int    cyc = 0;
      for (int n = 0; n < 260; n++) begin
         push(1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
         push(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
         push(1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 2'd0);
         bump_cnt();
         push(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 2'd1);
         wake_tail(1);
      end
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         apply_and_step(s);
         e = exp_q.pop_front();
         a = '{rdy: ready, w: wake, st: state, cnt: wcount};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL saturation cyc %0d: got rdy/wake/state/cnt=%b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     cyc, a.rdy, a.w, a.st, a.cnt, e.rdy, e.w, e.st, e.cnt);
         end
         cyc++;
      end
   endtask

   initial begin
      rst   = 1'b0;
      data  = 3'b000;
      valid = 1'b0;
      last  = 1'b0;
      ack   = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_wake();
      test_neg_breaks();
      test_ack();
      test_stream_through();
      test_reset_mid_wake();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
